// File: rtl/mem_layout_pkg.sv
// mem_layout_pkg: memory-map layout constants and shared types for the bigreg loaders
package mem_layout_pkg;
  localparam int MEM_SIZE         = 256;
  localparam int WD_DATA_WIDTH    = 16;
  localparam int PS_SEED_BASE_ID  = 1;
  localparam int PS_SEED_SAMPLES  = 16;
  localparam int CHAN_MUX_BASE_ID = 18;
  localparam int CHAN_MUX_SAMPLES = 4;
  localparam int SDC_BASE_ID      = 23;
  localparam int SDC_SAMPLES      = 8;
  typedef enum logic [1:0] {COLLECT, PRESENT, CLEAR} bigreg_state_t;
endpackage

// File: rtl/bigreg_loader_fresh_clear_seq.sv
// fresh_clear_seq: walks clr_id from BASE_ID to BASE_ID+WORDS, one address per clr_ack
module fresh_clear_seq #(
  parameter int BASE_ID = 1,
  parameter int WORDS   = 16,
  parameter int ID_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_clr_ack,
  output logic            o_clr_req,
  output logic [ID_W-1:0] o_clr_id,
  output logic            o_done
);
  logic            r_active;
  logic [ID_W-1:0] r_p;
  logic [ID_W-1:0] r_clr_id;
  logic            w_last;
  assign w_last    = r_p == ID_W'(WORDS);
  assign o_done    = r_active && i_clr_ack && w_last;
  assign o_clr_req = r_active;
  assign o_clr_id  = r_clr_id;
  // pointer advances on each ack; the ack of the VALID address ends the walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_p      <= '0;
      r_clr_id <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_p      <= '0;
      r_clr_id <= ID_W'(BASE_ID);
    end else if (r_active && i_clr_ack) begin
      r_active <= !w_last;
      r_p      <= w_last ? r_p : r_p + 1'b1;
      r_clr_id <= w_last ? r_clr_id : r_clr_id + 1'b1;
    end
  end
endmodule

// File: rtl/bigreg_loader.sv
// bigreg_loader: shadows a PS_BIGREG window and presents it as one wide word (stale check: BIGREG_STALE_CHECK_EN)
module bigreg_loader
  import mem_layout_pkg::*;
#(
  parameter int BASE_ID = PS_SEED_BASE_ID,
  parameter int WORDS   = PS_SEED_SAMPLES,
  parameter int WORD_W  = WD_DATA_WIDTH,
  parameter int ID_W    = $clog2(MEM_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ps_wr_en,
  input  logic [ID_W-1:0]         ps_wr_id,
  input  logic [WORD_W-1:0]       ps_wr_data,
  output logic                    big_valid,
  output logic [WORDS*WORD_W-1:0] big_data,
  input  logic                    rtl_rdy,
  output logic                    clr_req,
  output logic [ID_W-1:0]         clr_id,
  input  logic                    clr_ack,
  output logic                    seq_err,
  output logic                    busy
);
  localparam int VALID_ID = BASE_ID + WORDS;
`ifdef BIGREG_STALE_CHECK_EN
  localparam bit STALE_CHK = 1'b1;
`else
  localparam bit STALE_CHK = 1'b0;
`endif
  bigreg_state_t                  r_state, w_next;
  logic [WORDS-1:0][WORD_W-1:0]   r_shadow;
  logic [WORDS-1:0]               r_fresh;
  logic [WORDS*WORD_W-1:0]        r_big_data;
  logic                           r_big_valid;
  logic                           r_seq_err;
  logic [ID_W-1:0]                w_off;
  logic                           w_in_win, w_data_wr, w_valid_wr, w_collect;
  logic                           w_ready, w_present, w_err, w_start, w_done;
  assign w_off      = ps_wr_id - ID_W'(BASE_ID);
  assign w_in_win   = ps_wr_en && ps_wr_id >= ID_W'(BASE_ID) && ps_wr_id <= ID_W'(VALID_ID);
  assign w_data_wr  = w_in_win && w_off < ID_W'(WORDS);
  assign w_valid_wr = w_in_win && ps_wr_id == ID_W'(VALID_ID);
  assign w_collect  = r_state == COLLECT;
  assign w_ready    = !STALE_CHK || &r_fresh;
  assign w_present  = w_collect && w_valid_wr && w_ready;
  assign w_err      = w_in_win && (!w_collect || (w_valid_wr && !w_ready));
  assign big_valid  = r_big_valid;
  assign big_data   = r_big_data;
  assign seq_err    = r_seq_err;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_next;
  end
  // next state: present on a valid VALID write, clear after accept, collect after the last ack
  always_comb begin
    w_next = w_present ? PRESENT :
             w_start ? CLEAR :
             (r_state == CLEAR && w_done) ? COLLECT : r_state;
  end
  // state-decoded outputs
  always_comb begin
    busy    = !w_collect;
    w_start = r_state == PRESENT && rtl_rdy;
  end
  // shadow words and fresh bits, written only while collecting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_fresh  <= '0;
    end else if (w_collect && w_data_wr) begin
      for (int k = 0; k < WORDS; k++)
        if (w_off == ID_W'(k)) begin
          r_shadow[k] <= ps_wr_data;
          r_fresh[k]  <= 1'b1;
        end
    end else if (r_state == CLEAR && w_done) begin
      r_fresh <= '0;
    end
  end
  // captured value, valid flag and registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_big_valid <= 1'b0;
      r_big_data  <= '0;
      r_seq_err   <= 1'b0;
    end else begin
      r_seq_err <= w_err;
      if (w_present) begin
        r_big_valid <= 1'b1;
        r_big_data  <= r_shadow;
      end else if (w_start) begin
        r_big_valid <= 1'b0;
      end
    end
  end
  fresh_clear_seq #(
    .BASE_ID (BASE_ID),
    .WORDS   (WORDS),
    .ID_W    (ID_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_clr_ack (clr_ack),
    .o_clr_req (clr_req),
    .o_clr_id  (clr_id),
    .o_done    (w_done)
  );
endmodule

// File: tb/tb_bigreg_loader.sv
// tb_bigreg_loader: directed scoreboard bench for bigreg_loader
module tb_bigreg_loader;
  localparam int BASE = 1;
  localparam int W    = 16;
  localparam int WW   = 16;
  localparam int IW   = 8;
  localparam int VID  = BASE + W;
`ifdef BIGREG_STALE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic            clk = 0, rst_n = 0, ps_wr_en = 0, rtl_rdy = 0, clr_ack = 0;
  logic [IW-1:0]   ps_wr_id = '0;
  logic [WW-1:0]   ps_wr_data = '0;
  logic            big_valid, clr_req, seq_err, busy;
  logic [W*WW-1:0] big_data, held;
  logic [IW-1:0]   clr_id;
  int              n_cmp = 0, n_bad = 0, m_st;
  logic [WW-1:0]   m_sh[W];
  bit              m_fr[W];
  logic [W*WW-1:0] q_data[$];
  int              q_id[$];
  bigreg_loader dut (
    .clk(clk), .rst_n(rst_n), .ps_wr_en(ps_wr_en), .ps_wr_id(ps_wr_id),
    .ps_wr_data(ps_wr_data), .big_valid(big_valid), .big_data(big_data),
    .rtl_rdy(rtl_rdy), .clr_req(clr_req), .clr_id(clr_id), .clr_ack(clr_ack),
    .seq_err(seq_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W*WW-1:0] obs, input logic [W*WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W*WW-1:0] packm();
    logic [W*WW-1:0] r;
    for (int k = 0; k < W; k++) r[k*WW +: WW] = m_sh[k];
    return r;
  endfunction
  task automatic mreset;
    for (int k = 0; k < W; k++) begin
      m_sh[k] = '0;
      m_fr[k] = 1'b0;
    end
    m_st = 0;
  endtask
  task automatic wr(input int id, input logic [WW-1:0] d);
    bit exp_err, all;
    exp_err = 0;
    all = 1;
    ps_wr_en = 1;
    ps_wr_id = IW'(id);
    ps_wr_data = d;
    if (id >= BASE && id <= VID) begin
      if (m_st != 0) exp_err = 1;
      else if (id < VID) begin
        m_sh[id-BASE] = d;
        m_fr[id-BASE] = 1;
      end else begin
        for (int k = 0; k < W; k++) all &= m_fr[k];
        if (all || !CHK) begin
          q_data.push_back(packm());
          m_st = 1;
        end else exp_err = 1;
      end
    end
    tick;
    ps_wr_en = 0;
    chk("seq_err", seq_err, exp_err);
    chk("big_valid", big_valid, m_st == 1);
    if (big_valid && q_data.size() != 0) chk("big_data", big_data, q_data.pop_front());
  endtask
  task automatic accept;
    rtl_rdy = 1;
    tick;
    rtl_rdy = 0;
    chk("acc_valid", big_valid, 0);
    chk("acc_busy", busy, 1);
    chk("acc_clr_req", clr_req, 1);
    for (int i = 0; i <= W; i++) q_id.push_back(BASE + i);
    m_st = 2;
  endtask
  task automatic run_clear(input int stall_id, input bit wr_last);
    int e;
    for (int i = 0; i <= W; i++) begin
      e = q_id.pop_front();
      if (e == stall_id) begin
        clr_ack = 0;
        repeat (3) begin
          tick;
          chk("stall_id", clr_id, e);
          chk("stall_req", clr_req, 1);
        end
      end
      chk("clr_req", clr_req, 1);
      chk("clr_id", clr_id, e);
      chk("clr_busy", busy, 1);
      clr_ack = 1;
      if (wr_last && i == W) begin
        ps_wr_en = 1;
        ps_wr_id = IW'(BASE + 1);
        ps_wr_data = 16'h7777;
      end
      tick;
      clr_ack = 0;
      if (wr_last && i == W) begin
        ps_wr_en = 0;
        chk("late_wr_err", seq_err, 1);
      end
    end
    for (int k = 0; k < W; k++) m_fr[k] = 0;
    m_st = 0;
    chk("done_busy", busy, 0);
    chk("done_clr_req", clr_req, 0);
  endtask
  initial begin
    mreset;
    #12;
    chk("rst_valid", big_valid, 0);
    chk("rst_clr_req", clr_req, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", big_data, 0);
    chk("rst_clr_id", clr_id, 0);
    tick;
    rst_n = 1;
    tick;
    wr(VID, 0);
    tick;
    chk("err_one_cycle", seq_err, 0);
    if (m_st == 1) begin
      accept;
      run_clear(-1, 0);
    end
    for (int k = 0; k < W; k++) wr(BASE + k, WW'(16'h1000 + k));
    wr(VID, 0);
    held = big_data;
    wr(BASE + 2, 16'hDEAD);
    chk("busy_wr_data", big_data, held);
    wr(100, 16'h5555);
    wr(0, 16'h5555);
    repeat (10) begin
      tick;
      chk("bp_valid", big_valid, 1);
      chk("bp_data", big_data, held);
    end
    accept;
    run_clear(5, 0);
    for (int k = 0; k < W - 1; k++) wr(BASE + k, WW'(16'h2000 + k));
    wr(VID, 0);
    tick;
    chk("miss_err_pulse", seq_err, 0);
    if (m_st == 1) begin
      accept;
      run_clear(-1, 0);
    end
    wr(BASE + W - 1, 16'hBEEF);
    wr(VID, 0);
    chk("word15", big_data[(W-1)*WW +: WW], 16'hBEEF);
    accept;
    run_clear(-1, 1);
    for (int k = 0; k < W; k++) wr(BASE + k, WW'($urandom));
    rtl_rdy = 1;
    wr(VID, 0);
    accept;
    clr_ack = 1;
    for (int i = 0; i < 40 && clr_id != 9; i++) tick;
    chk("reach_id9", clr_id, 9);
    #3 rst_n = 0;
    #1;
    chk("arst_clr_req", clr_req, 0);
    chk("arst_valid", big_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_clr_id", clr_id, 0);
    clr_ack = 0;
    q_id.delete();
    mreset;
    tick;
    rst_n = 1;
    tick;
    for (int k = 0; k < W; k++) wr(BASE + k, WW'(16'h3000 + 3 * k));
    wr(VID, 0);
    accept;
    run_clear(-1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
